// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types for the modulo PC unit
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0] pc_t;

  // Next-PC source chosen by the priority decoder
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_RET,
    SEL_EXC
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address LIFO
module ras_stack #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;      // next slot to write; top entry sits just below it
  logic [PW:0]   r_count;

  logic [PW-1:0] w_top_idx;
  logic          w_do_pop;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_do_pop  = pop & ~empty;
  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign top_data  = r_mem[w_top_idx];

  // Pointer and occupancy; a push when full wraps and overwrites the oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_pop && push) begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
    end else if (w_do_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PW+1)'(1);
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full) begin
        r_count <= r_count + (PW+1)'(1);
      end
    end
  end

  // Entry storage is deliberately not reset; simultaneous push/pop replaces the top
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[w_do_pop ? w_top_idx : r_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/modulo_pc_ras.sv
// rtl/modulo_pc_ras.sv - program counter with stall, exception vector and RAS
module modulo_pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] INC          = XLEN'(4),
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0008),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] result,
  input  logic            call,
  input  logic            ret,
  input  logic            exc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            redirect,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] r_pc;
  logic            r_redirect;

  pc_sel_e         w_sel;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_ras_top;
  logic            w_push;
  logic            w_pop;

  assign pc          = r_pc;
  assign pc_next_seq = r_pc + INC;
  assign redirect    = r_redirect;

  // Priority decode: exception, return, branch, stall, sequential
  always_comb begin
    w_sel = SEL_SEQ;
    if (exc) begin
      w_sel = SEL_EXC;
    end else if (ret) begin
      // Return with nothing stacked falls back to the result bus target
      w_sel = ras_empty ? SEL_BR : SEL_RET;
    end else if (PCSrc) begin
      w_sel = SEL_BR;
    end else if (stall) begin
      w_sel = SEL_HOLD;
    end
  end

  assign w_push = ~exc & ~ret & PCSrc & call;
  assign w_pop  = (w_sel == SEL_RET);

  // Next-PC mux driven by the decoded selector
  always_comb begin
    w_pc_next = pc_next_seq;
    unique case (w_sel)
      SEL_HOLD: w_pc_next = r_pc;
      SEL_BR:   w_pc_next = result;
      SEL_RET:  w_pc_next = w_ras_top;
      SEL_EXC:  w_pc_next = EXC_VECTOR;
      default:  w_pc_next = pc_next_seq;
    endcase
  end

  // PC register and one-cycle redirect flag for the fetch stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_VECTOR;
      r_redirect <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_redirect <= (w_sel == SEL_BR) || (w_sel == SEL_RET) || (w_sel == SEL_EXC);
    end
  end

  ras_stack #(
    .W     (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_next_seq),
    .top_data  (w_ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_modulo_pc_ras.sv
// tb/tb_modulo_pc_ras.sv - table-driven bench for modulo_pc_ras
module tb_modulo_pc_ras;
  import pc_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        PCSrc;
  logic [31:0] result;
  logic        call;
  logic        ret;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;

  int n_total;
  int n_pass;

  typedef struct {
    logic        st;
    logic        pcs;
    logic        cl;
    logic        rt;
    logic        ex;
    logic [31:0] res;
    logic [31:0] e_pc;
    logic        e_red;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t tbl[$];

  modulo_pc_ras dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .result      (result),
    .call        (call),
    .ret         (ret),
    .exc         (exc),
    .pc          (pc),
    .pc_next_seq (pc_next_seq),
    .redirect    (redirect),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t v(input logic st, input logic pcs, input logic cl,
                             input logic rt, input logic ex, input logic [31:0] res,
                             input logic [31:0] e_pc, input logic e_red,
                             input logic e_empty, input logic e_full);
    vec_t r;
    r.st = st; r.pcs = pcs; r.cl = cl; r.rt = rt; r.ex = ex; r.res = res;
    r.e_pc = e_pc; r.e_red = e_red; r.e_empty = e_empty; r.e_full = e_full;
    return r;
  endfunction

  task automatic drive(input logic st, input logic pcs, input logic cl,
                       input logic rt, input logic ex, input logic [31:0] res);
    stall = st; PCSrc = pcs; call = cl; ret = rt; exc = ex; result = res;
  endtask

  task automatic step(input vec_t t, input string tag);
    drive(t.st, t.pcs, t.cl, t.rt, t.ex, t.res);
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc, t.e_pc);
    chk({tag, ".seq"}, pc_next_seq, t.e_pc + 32'd4);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, t.e_red});
    chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, t.e_empty});
    chk({tag, ".full"}, {31'd0, ras_full}, {31'd0, t.e_full});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;

    // Reset held for 20 ns with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      #4;
      chk("rst.pc", pc, 32'h0);
      chk("rst.redirect", {31'd0, redirect}, 32'd0);
      chk("rst.empty", {31'd0, ras_empty}, 32'd1);
      chk("rst.full", {31'd0, ras_full}, 32'd0);
      #1;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h0);
    reset = 1'b1;

    //              st pcs cl rt ex result         pc            red emp full
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'h4,         0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'h8,         0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'hC,         0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd30,         32'd30,        1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'd34,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h40,         32'h40,        1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h100,        32'h100,       1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'h104,       0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'h108,       0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'hDEAD,       32'h44,        1, 1, 0));
    // Five calls: push A=0x48, B=0x1004, C=0x2004, D=0x3004, E=0x4004
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h1000,       32'h1000,      1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h2000,       32'h2000,      1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h3000,       32'h3000,      1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h4000,       32'h4000,      1, 0, 1));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h5000,       32'h5000,      1, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,          32'h4004,      1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,          32'h3004,      1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,          32'h2004,      1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,          32'h1004,      1, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h200,        32'h200,       1, 1, 0));
    // Priority
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,          32'h200,       0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,          32'h200,       0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,          32'h200,       0, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h80,         32'h80,        1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h300,        32'h300,       1, 0, 0));
    tbl.push_back(v(1, 1, 1, 1, 1, 32'h999,        32'h8,         1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,          32'h84,        1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 32'h700,        32'h88,        0, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 32'h500,        32'h500,       1, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h504,        32'h504,       1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,          32'h508,       0, 1, 0));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Mid-stream reset with two entries stacked
    step(v(0, 1, 1, 0, 0, 32'h600, 32'h600, 1, 0, 0), "mr0");
    step(v(0, 1, 1, 0, 0, 32'h700, 32'h700, 1, 0, 0), "mr1");
    drive(0, 1, 1, 0, 0, 32'h800);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst.pc", pc, 32'h0);
    chk("mid_rst.empty", {31'd0, ras_empty}, 32'd1);
    chk("mid_rst.redirect", {31'd0, redirect}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst.hold_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(v(0, 0, 0, 0, 0, 32'h0, 32'h4, 0, 1, 0), "post_rst");

    // Wrap from the top of the address space
    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap.pc", pc, 32'hFFFF_FFFC);
    chk("wrap.seq", pc_next_seq, 32'h0);
    step(v(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0), "wrap_step");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/modulo_pc_ras.md
Name: modulo_pc_ras

Overview:
Parametrised program-counter unit that supersedes the single-mux PC register of the core. It adds a stall, a synchronous exception vector and a small return-address stack (RAS) for call/return redirection. It also drives a one-cycle redirect indication to the fetch stage. It sits between the branch/writeback result bus and instruction memory.

Parameters:
XLEN, 32, width of PC and all address buses
INC, 4, increment added per sequential fetch
RESET_VECTOR, 32'h0000_0000, PC value held during and after reset
EXC_VECTOR, 32'h0000_0008, PC loaded on exception
RAS_DEPTH, 4, RAS entries; must be a power of 2 and at least 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 = reset asserted
stall  in  1  hold PC; lower priority than exc and redirect
PCSrc  in  1  take branch/jump to result
result  in  XLEN  branch/jump target
call  in  1  qualifies PCSrc as a call; push return address
ret  in  1  return; pop RAS and redirect to the popped entry
exc  in  1  exception; load EXC_VECTOR
pc  out  XLEN  current fetch address
pc_next_seq  out  XLEN  pc + INC (combinational)
redirect  out  1  registered; high for the cycle after any non-sequential PC load
ras_empty  out  1  RAS holds 0 valid entries
ras_full  out  1  RAS holds RAS_DEPTH valid entries

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_VECTOR, redirect = 0.
  - RAS count = 0 and top pointer = 0, so ras_empty = 1 and ras_full = 0.
  - RAS storage contents are not reset.
- Release is synchronous to the design's reset release. The first rising edge after release applies the normal rules below.
- Per-edge priority, highest first:
  1. exc=1: pc <= EXC_VECTOR. RAS untouched. call, ret, PCSrc and stall are ignored.
  2. ret=1 with RAS not empty: pc <= top entry; pop (count-1).
  3. ret=1 with RAS empty: pc <= result (fallback target); no pop; count stays 0.
  4. PCSrc=1: pc <= result. If call=1, push pc+INC.
  5. stall=1: pc holds; no RAS change.
  6. Otherwise: pc <= pc + INC.
- Redirects ignore stall: a redirect never waits.
- call without PCSrc has no effect. ret together with PCSrc: ret wins and PCSrc is ignored.
- Push on a full RAS: write at the wrapped top pointer, overwriting the oldest entry. Count stays RAS_DEPTH (circular behaviour, no error).
- Arithmetic is modulo 2^XLEN. pc+INC wraps from 32'hFFFF_FFFC to 0 with no flag.
- redirect <= 1 on any edge taking rule 1, 2, 3 or 4 (including a branch to pc+INC); otherwise 0.
- Latency: the new pc is visible one cycle after the edge that samples the request. pc_next_seq follows pc combinationally.
- Reset mid-stream clears the RAS immediately; pending requests are lost.

Decomposition:
- Package pc_pkg:
  - XLEN default constant.
  - Typedef pc_t (logic [XLEN-1:0]).
  - Enum pc_sel_e {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_RET, SEL_EXC} used by the priority decoder.
- One sub-module, ras_stack: parametrised circular LIFO.
  - Inputs: push, pop, push_data.
  - Outputs: top_data, empty, full.
  - Same clk/reset.
- The top level contains the priority decoder, PC register and redirect flop.

Test Plan:
1. Hold reset=0 for 20 ns with random inputs -> pc=0, redirect=0, ras_empty=1 throughout. Release and run 3 plain edges -> pc = 4, 8, 12.
2. pc=12, PCSrc=1, result=30 for one edge -> pc=30, redirect=1 for one cycle. Next plain edge -> pc=34, redirect=0.
3. Call then return:
   - Call: pc=0x40, PCSrc=1, call=1, result=0x100 -> pc=0x100, RAS top=0x44.
   - Plain edges advance pc to 0x108.
   - ret=1 -> pc=0x44, ras_empty=1.
4. RAS overflow, RAS_DEPTH=4:
   - 5 calls pushing A, B, C, D, E -> ras_full=1.
   - 4 rets return E, D, C, B; A is overwritten. Then ras_empty=1.
   - 5th ret with result=0x200 -> pc=0x200.
5. Priority:
   - stall=1 for 3 edges -> pc constant.
   - stall=1 with PCSrc=1, result=0x80 -> pc=0x80.
   - exc=1 with ret=1 and PCSrc=1 -> pc=EXC_VECTOR, RAS count unchanged.
6. Reset mid-operation: 2 entries pushed, assert reset between edges -> pc=0 immediately and ras_empty=1. Wrap check: pc=32'hFFFF_FFFC, plain edge -> pc=0.
